// File: rtl/pix_pkg.sv
// Shared definitions for the window scan controller: pixel width, default
// frame geometry and the scan state encoding.
package pix_pkg;

    localparam int PIX_W     = 5;
    localparam int IMG_W_DEF = 100;
    localparam int IMG_H_DEF = 100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Control/handshake bundle between the column source, the window datapath
// and the scan controller.
interface window_scan_ctrl_if #(
    parameter int IMG_W = pix_pkg::IMG_W_DEF,
    parameter int IMG_H = pix_pkg::IMG_H_DEF
);

    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // A column transfers on every cycle where in_valid && in_ready, and that
    // transfer is reported as win_shift; in_valid need not be held and is
    // dropped while in_ready is low. out_valid is a one-cycle strobe with no
    // back-pressure.
    logic          start;
    logic          mode;
    logic          in_valid;
    logic          load_end;
    logic          in_ready;
    logic          win_shift;
    logic          win_clear;
    logic          dp_mode;
    logic          out_valid;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;
    logic          busy;
    logic          done;
    logic          len_err;
    pix_pkg::scan_state_t scan_state;

    modport master (
        output start, mode, in_valid, load_end,
        input  in_ready, win_shift, win_clear, dp_mode, out_valid,
               col_idx, row_idx, busy, done, len_err, scan_state
    );

    modport slave (
        input  start, mode, in_valid, load_end,
        output in_ready, win_shift, win_clear, dp_mode, out_valid,
               col_idx, row_idx, busy, done, len_err, scan_state
    );

endinterface

// File: rtl/valid_delay.sv
// Fixed-latency result strobe: a DEPTH-deep shift register of accepted columns
// with an asynchronous active-low clear.
module valid_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic pending
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

    // Strobes still travelling; the one in the output stage issues this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | sr[i];
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Band-by-band 3x3 window scan controller. Optional band-length checking is
// enabled by defining SCAN_LEN_CHECK_EN.
module window_scan_ctrl
    import pix_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int PIPE_LAT = 1
) (
    input logic clk,
    input logic reset,
    window_scan_ctrl_if.slave bus
);

    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    scan_state_t   state, state_nx;
    logic [CW-1:0] col_cnt, res_cnt;
    logic [RW-1:0] row_cnt;
    logic          mode_q, busy_q;
    logic          accept, in_ready, win_clear, done, out_valid, pending;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        win_clear = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE:  if (bus.start) state_nx = S_CLEAR;
            S_CLEAR: begin
                win_clear = 1'b1;
                state_nx  = S_FILL;
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (bus.load_end)            state_nx = S_FLUSH;
                    else if (col_cnt == CW'(1))  state_nx = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.load_end) state_nx = S_FLUSH;
            end
            S_FLUSH: if (!pending) state_nx = (row_cnt == ROW_LAST) ? S_DONE : S_CLEAR;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept = bus.in_valid & in_ready;

    // Column and result counters both saturate at the last padded column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            col_cnt <= '0;
            res_cnt <= '0;
            row_cnt <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && bus.start) begin
                mode_q  <= bus.mode;
                row_cnt <= '0;
                busy_q  <= 1'b1;
            end
            if (state == S_DONE) busy_q <= 1'b0;
            if (state == S_FLUSH && !pending && row_cnt != ROW_LAST)
                row_cnt <= row_cnt + RW'(1);
            if (state == S_CLEAR) begin
                col_cnt <= '0;
                res_cnt <= '0;
            end else begin
                if (accept && col_cnt != COL_LAST)    col_cnt <= col_cnt + CW'(1);
                if (out_valid && res_cnt != COL_LAST) res_cnt <= res_cnt + CW'(1);
            end
        end
    end

    // The first two columns of a band only prime the window.
    valid_delay #(.DEPTH(PIPE_LAT)) u_valid_delay (
        .clk     (clk),
        .rst_n   (reset),
        .din     (accept && state == S_RUN),
        .dout    (out_valid),
        .pending (pending)
    );

`ifdef SCAN_LEN_CHECK_EN
    logic len_err_q, last_seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_err_q <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start)
                len_err_q <= 1'b0;
            else if (accept && ((bus.load_end && col_cnt != COL_LAST) || last_seen))
                len_err_q <= 1'b1;
            if (state == S_CLEAR)                 last_seen <= 1'b0;
            else if (accept && col_cnt == COL_LAST) last_seen <= 1'b1;
        end
    end

    assign bus.len_err = len_err_q;
`else
    assign bus.len_err = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.win_shift  = accept;
    assign bus.win_clear  = win_clear;
    assign bus.dp_mode    = mode_q;
    assign bus.out_valid  = out_valid;
    assign bus.col_idx    = res_cnt;
    assign bus.row_idx    = row_cnt;
    assign bus.busy       = busy_q;
    assign bus.done       = done;
    assign bus.scan_state = state;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: per-cycle vector table for whole
// frames plus hand sequences for mid-frame reset and a 3-cycle pipeline.
module tb_window_scan_ctrl;
    import pix_pkg::*;

`ifdef SCAN_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ov3_cnt = 0;
    logic [39:0] exp_q[$];
    logic [39:0] exp_e;

    window_scan_ctrl_if #(.IMG_W(4), .IMG_H(2)) bus ();
    window_scan_ctrl_if #(.IMG_W(4), .IMG_H(1)) bus3 ();

    window_scan_ctrl #(.IMG_W(4), .IMG_H(2), .PIPE_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    window_scan_ctrl #(.IMG_W(4), .IMG_H(1), .PIPE_LAT(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] inp;   // {start, mode, in_valid, load_end}
        logic [3:0] fl;    // {in_ready, win_shift, win_clear, out_valid}
        int         col;   // -1: not compared
        logic       row, dp, busy, done, len;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] inp, input logic [3:0] fl, input int col,
                       input logic row, input logic dp, input logic busy,
                       input logic done, input logic len);
        vec_t v;
        v.inp = inp; v.fl = fl; v.col = col;
        v.row = row; v.dp = dp; v.busy = busy; v.done = done; v.len = len & LEN_CHK;
        tbl.push_back(v);
    endtask

    // driver tasks
    task automatic drive(input logic [3:0] inp);
        bus.start = inp[3]; bus.mode = inp[2]; bus.in_valid = inp[1]; bus.load_end = inp[0];
    endtask

    task automatic drive3(input logic [3:0] inp);
        bus3.start = inp[3]; bus3.mode = inp[2]; bus3.in_valid = inp[1]; bus3.load_end = inp[0];
    endtask

    task automatic idle_cycle(input logic [3:0] inp);
        drive(inp);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  int'(bus.in_ready), 0);
        chk({tag, "_win_shift"}, int'(bus.win_shift), 0);
        chk({tag, "_win_clear"}, int'(bus.win_clear), 0);
        chk({tag, "_dp_mode"},   int'(bus.dp_mode), 0);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_col_idx"},   int'(bus.col_idx), 0);
        chk({tag, "_row_idx"},   int'(bus.row_idx), 0);
        chk({tag, "_busy"},      int'(bus.busy), 0);
        chk({tag, "_done"},      int'(bus.done), 0);
        chk({tag, "_len_err"},   int'(bus.len_err), 0);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].inp);
            @(negedge clk);
            chk($sformatf("r%0d_in_ready", i),  int'(bus.in_ready),  int'(tbl[i].fl[3]));
            chk($sformatf("r%0d_win_shift", i), int'(bus.win_shift), int'(tbl[i].fl[2]));
            chk($sformatf("r%0d_win_clear", i), int'(bus.win_clear), int'(tbl[i].fl[1]));
            chk($sformatf("r%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].fl[0]));
            if (tbl[i].col >= 0)
                chk($sformatf("r%0d_col_idx", i), int'(bus.col_idx), tbl[i].col);
            chk($sformatf("r%0d_row_idx", i), int'(bus.row_idx), int'(tbl[i].row));
            chk($sformatf("r%0d_dp_mode", i), int'(bus.dp_mode), int'(tbl[i].dp));
            chk($sformatf("r%0d_busy", i),    int'(bus.busy),    int'(tbl[i].busy));
            chk($sformatf("r%0d_done", i),    int'(bus.done),    int'(tbl[i].done));
            chk($sformatf("r%0d_len_err", i), int'(bus.len_err), int'(tbl[i].len));
            @(posedge clk); #1;
        end
    endtask

    // scoreboard for the PIPE_LAT=3 instance: {cycle, col_idx}
    always @(negedge clk) begin
        if (bus3.out_valid) begin
            ov3_cnt++;
            chk("lat3_result_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk("lat3_cycle", cyc, int'(exp_e[39:8]));
                chk("lat3_col", int'(bus3.col_idx), int'(exp_e[7:0]));
            end
        end
    end

    initial begin
        // frame A (rows 0..19): mode 1, two 6-column bands, restart/mode noise
        add(4'b1100, 4'b0000, -1, 0, 0, 0, 0, 0);
        add(4'b0010, 4'b0010, -1, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b1010, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b1101,  0, 0, 1, 1, 0, 0);
        add(4'b0001, 4'b1001,  1, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b0011, 4'b1101,  2, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b0001,  3, 0, 1, 1, 0, 0);
        add(4'b0000, 4'b0010, -1, 1, 1, 1, 0, 0);
        add(4'b0110, 4'b1100, -1, 1, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 1, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 1, 1, 1, 0, 0);
        add(4'b0010, 4'b1101,  0, 1, 1, 1, 0, 0);
        add(4'b0010, 4'b1101,  1, 1, 1, 1, 0, 0);
        add(4'b0011, 4'b1101,  2, 1, 1, 1, 0, 0);
        add(4'b0000, 4'b0001,  3, 1, 1, 1, 0, 0);
        add(4'b0000, 4'b0000, -1, 1, 1, 1, 1, 0);
        add(4'b0000, 4'b0000, -1, 1, 1, 0, 0, 0);
        // frame B (rows 20..38): 9-column band then 3-column band
        add(4'b1000, 4'b0000, -1, 1, 1, 0, 0, 0);
        add(4'b0000, 4'b0010, -1, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1101,  0, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1101,  1, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1101,  2, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1101,  3, 0, 0, 1, 0, 0);
        add(4'b0010, 4'b1101,  4, 0, 0, 1, 0, 1);
        add(4'b0011, 4'b1101,  5, 0, 0, 1, 0, 1);
        add(4'b0000, 4'b0001,  5, 0, 0, 1, 0, 1);
        add(4'b0000, 4'b0010, -1, 1, 0, 1, 0, 1);
        add(4'b0010, 4'b1100, -1, 1, 0, 1, 0, 1);
        add(4'b0010, 4'b1100, -1, 1, 0, 1, 0, 1);
        add(4'b0011, 4'b1100, -1, 1, 0, 1, 0, 1);
        add(4'b0000, 4'b0001,  0, 1, 0, 1, 0, 1);
        add(4'b0000, 4'b0000, -1, 1, 0, 1, 1, 1);
        add(4'b0000, 4'b0000, -1, 1, 0, 0, 0, 1);
        // frame C (rows 39..48): bands terminated while still filling
        add(4'b1100, 4'b0000, -1, 1, 0, 0, 0, 1);
        add(4'b0000, 4'b0010, -1, 0, 1, 1, 0, 0);
        add(4'b0010, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b0011, 4'b1100, -1, 0, 1, 1, 0, 0);
        add(4'b0000, 4'b0000, -1, 0, 1, 1, 0, 1);
        add(4'b0000, 4'b0010, -1, 1, 1, 1, 0, 1);
        add(4'b0011, 4'b1100, -1, 1, 1, 1, 0, 1);
        add(4'b0000, 4'b0000, -1, 1, 1, 1, 0, 1);
        add(4'b0000, 4'b0000, -1, 1, 1, 1, 1, 1);
        add(4'b0000, 4'b0000, -1, 1, 1, 0, 0, 1);

        // reset block
        reset = 1'b0;
        drive(4'b1111);
        drive3(4'b0000);
        #2;
        chk_reset_vals("reset");
        drive(4'b0000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run_rows(0, 48);

        // reset during RUN of the second band
        idle_cycle(4'b1100);
        idle_cycle(4'b0000);
        for (int k = 0; k < 6; k++) idle_cycle({3'b001, k == 5});
        idle_cycle(4'b0000);
        idle_cycle(4'b0000);
        for (int k = 0; k < 3; k++) idle_cycle(4'b0010);
        drive(4'b0010);
        #1;
        chk("pre_rst_out_valid", int'(bus.out_valid), 1);
        chk("pre_rst_row_idx", int'(bus.row_idx), 1);
        chk("pre_rst_busy", int'(bus.busy), 1);
        #1 reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        drive(4'b0000);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done%0d", k), int'(bus.done), 0);
            chk($sformatf("post_rst_busy%0d", k), int'(bus.busy), 0);
        end
        @(posedge clk); #1;
        run_rows(0, 19);

        // PIPE_LAT=3, single 6-column band
        drive3(4'b1000);
        @(negedge clk);
        @(posedge clk); #1;
        drive3(4'b0000);
        @(negedge clk);
        chk("lat3_clear", int'(bus3.win_clear), 1);
        @(posedge clk); #1;
        for (int j = 0; j < 6; j++) begin
            drive3({3'b001, j == 5});
            if (j >= 2) exp_q.push_back({32'(cyc + 3), 8'(j - 2)});
            @(negedge clk);
            chk($sformatf("lat3_shift%0d", j), int'(bus3.win_shift), 1);
            @(posedge clk); #1;
        end
        drive3(4'b0000);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j < 3) begin
                chk($sformatf("lat3_flush_state%0d", j), int'(bus3.scan_state), int'(S_FLUSH));
                chk($sformatf("lat3_flush_ready%0d", j), int'(bus3.in_ready), 0);
                chk($sformatf("lat3_flush_done%0d", j), int'(bus3.done), 0);
            end else if (j == 3) begin
                chk("lat3_done", int'(bus3.done), 1);
            end else begin
                chk("lat3_idle_busy", int'(bus3.busy), 0);
            end
            @(posedge clk); #1;
        end
        chk("lat3_queue_empty", exp_q.size(), 0);
        chk("lat3_result_count", ov3_cnt, 4);

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 100, output pixels per row; padded band length is IMG_W+2 columns.
REQ-002 SHALL have parameter IMG_H, default 100, output rows per frame.
REQ-003 SHALL have parameter PIPE_LAT, default 1, datapath cycles from column accept to result (range 1..4).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle frame start request.
REQ-007 SHALL have port mode  in  1  filter select (0 median, 1 edge), sampled on accepted start.
REQ-008 SHALL have port in_valid  in  1  a 3-pixel column (pixel_in0..2) is present.
REQ-009 SHALL have port load_end  in  1  qualifies in_valid; marks last column of the current band.
REQ-010 SHALL have port in_ready  out  1  controller accepts a column this cycle.
REQ-011 SHALL have port win_shift  out  1  shift the 3x3 window by one column (= in_valid & in_ready).
REQ-012 SHALL have port win_clear  out  1  one-cycle window flush at band start.
REQ-013 SHALL have port dp_mode  out  1  latched filter select for the datapath.
REQ-014 SHALL have port out_valid  out  1  edge_out/pixel_out hold a valid result.
REQ-015 SHALL have ports col_idx/row_idx  out  $clog2(IMG_W+2)/$clog2(IMG_H)  position of current result.
REQ-016 SHALL have ports busy, done, len_err  out  1  frame active; one-cycle frame completion; band-length error.

Function
REQ-017 SHALL implement states IDLE, CLEAR, FILL, RUN, FLUSH, DONE.
REQ-018 IDLE: in_ready=0; start -> CLEAR, latch dp_mode<=mode, row_idx<=0, busy<=1.
REQ-019 CLEAR: win_clear=1 for exactly one cycle, in_ready=0, column counter<=0; -> FILL.
REQ-020 FILL: in_ready=1; accepts first two columns with no result; after second accept -> RUN.
REQ-021 RUN: in_ready=1; each accepted column schedules out_valid exactly PIPE_LAT cycles later; col_idx increments per out_valid, starting at 0.
REQ-022 Accepted column with load_end in FILL or RUN -> FLUSH.
REQ-023 FLUSH: in_ready=0; wait until all scheduled out_valid pulses issue; then row_idx==IMG_H-1 -> DONE, else row_idx+1 -> CLEAR.
REQ-024 DONE: done=1 one cycle, busy<=0; -> IDLE.
REQ-025 start while busy SHALL be ignored; mode changes while busy SHALL not alter dp_mode.
REQ-026 in_valid while in_ready=0 SHALL be dropped (no win_shift, no count change); load_end without in_valid ignored.
REQ-027 Band with >IMG_W+2 columns (no load_end by column IMG_W+1): column counter saturates at IMG_W+1, extra results still emitted, col_idx saturates.
REQ-028 load_end in FILL (band <3 columns): no results for that band; proceed to FLUSH normally.

Reset
REQ-029 reset low SHALL force IDLE immediately, cancel pending out_valid, and clear all counters.
REQ-030 Reset values: in_ready 0, win_shift 0, win_clear 0, dp_mode 0, out_valid 0, col_idx 0, row_idx 0, busy 0, done 0, len_err 0.
REQ-031 Reset mid-frame SHALL discard the frame; no done pulse.

Configuration
REQ-032 SCAN_LEN_CHECK_EN defined: len_err set (sticky until next accepted start) when load_end arrives on column index != IMG_W+1 or band exceeds IMG_W+2 columns.
REQ-033 SCAN_LEN_CHECK_EN undefined: len_err tied 0; load_end is sole band terminator; all other behaviour identical.

Structure
REQ-034 Shared package pix_pkg SHALL hold PIX_W=5, default IMG_W/IMG_H, and the scan state enum.
REQ-035 One sub-module valid_delay (PIPE_LAT-deep shift register, async active-low clear) SHALL generate out_valid; FSM and counters stay in window_scan_ctrl.

Verification (IMG_W=4, IMG_H=2, PIPE_LAT=1)
REQ-036 start, mode=1, 6 columns per band, load_end on 6th, two bands -> win_clear twice, 8 out_valid with col_idx 0..3 per row, row_idx 0 then 1, done one cycle after last FLUSH.
REQ-037 mode toggled 0->1 mid-frame, start re-pulsed -> dp_mode stays 1 from original start, no restart.
REQ-038 load_end on 3rd column -> 1 result, FLUSH; with SCAN_LEN_CHECK_EN len_err=1, without len_err=0.
REQ-039 in_valid during CLEAR and FLUSH -> no win_shift, counts unchanged.
REQ-040 reset low during RUN of band 1 -> all outputs reset values same cycle, no done; new start runs full frame correctly.
REQ-041 PIPE_LAT=3, one band -> each out_valid exactly 3 cycles after its win_shift; FLUSH lasts until third pending result issues.
